// File: rtl/barrett_reducer.sv
// Pipelined Barrett reduction of a 512-bit product modulo a 256-bit modulus.
// Six register levels: X sampled at edge 0 emerges on R/out_valid at edge 5.
module barrett_reducer #(
    parameter logic [255:0] MODULUS = {{248{1'b1}}, 8'h43},
    parameter logic [256:0] MU      = {1'b1, 248'd0, 8'hBD}
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [511:0] X,
    input  logic         in_valid,
    output logic [255:0] R,
    output logic         out_valid
);

    localparam logic [257:0] ModWide = {2'b00, MODULUS};

    // Stage valid bits shift unconditionally.
    logic v1_q, v2_q, v3_q, v4_q, v5_q;

    // Stage data registers load only when the incoming valid is set.
    logic [256:0] q1_q;
    logic [257:0] x1_q;
    logic [256:0] q3_q;
    logic [257:0] x2_q;
    logic [257:0] t_q;
    logic [257:0] x3_q;
    logic [257:0] r_q;
    logic [257:0] r1_q;

    // Next-state datapath values.
    logic [513:0] q2;
    logic [256:0] q3_d;
    logic [256:0] unused_q2_lo;
    logic [257:0] t_d;
    logic [257:0] r_d;
    logic [257:0] r1_d;
    logic [257:0] r2;
    logic [1:0]   unused_r2_hi;

    always_comb begin
        q2           = {257'd0, q1_q} * {257'd0, MU};
        q3_d         = q2[513:257];
        unused_q2_lo = q2[256:0];
        // Only the low 258 bits of q3*MODULUS matter since r < 3*MODULUS < 2^258.
        t_d          = {1'b0, q3_q} * ModWide;
        r_d          = x3_q - t_q;
        r1_d         = (r_q >= ModWide) ? (r_q - ModWide) : r_q;
        r2           = (r1_q >= ModWide) ? (r1_q - ModWide) : r1_q;
        unused_r2_hi = r2[257:256];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            v4_q      <= 1'b0;
            v5_q      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1_q      <= in_valid;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            v4_q      <= v3_q;
            v5_q      <= v4_q;
            out_valid <= v5_q;
        end
    end

    // S1: split the input into the Barrett estimate operand and the low residue bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q1_q <= '0;
            x1_q <= '0;
        end else if (in_valid) begin
            q1_q <= X[511:255];
            x1_q <= X[257:0];
        end
    end

    // S2: quotient estimate q3 = floor(q1*MU / 2^257).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q3_q <= '0;
            x2_q <= '0;
        end else if (v1_q) begin
            q3_q <= q3_d;
            x2_q <= x1_q;
        end
    end

    // S3: t = q3*MODULUS mod 2^258.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            t_q  <= '0;
            x3_q <= '0;
        end else if (v2_q) begin
            t_q  <= t_d;
            x3_q <= x2_q;
        end
    end

    // S4: wrapping subtract, then the first conditional correction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (v3_q) begin
            r_q <= r_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r1_q <= '0;
        end else if (v4_q) begin
            r1_q <= r1_d;
        end
    end

    // S5: second correction; R holds its last result while no new one arrives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            R <= '0;
        end else if (v5_q) begin
            R <= r2[255:0];
        end
    end

endmodule
